// File: rtl/rf_wb_queue_if.sv
// Handshake bundle between the pipeline, the write-back queue and the register
// file. It carries the push side, the drained RF write and both forwarding ports.
interface rf_wb_queue_if #(
    parameter int SEL_W  = 3,
    parameter int DATA_W = 16
);
    logic              push_valid;
    logic [SEL_W-1:0]  push_sel;
    logic [DATA_W-1:0] push_data;
    logic              push_ready;

    logic              drain_en;
    logic              rf_writeEn;
    logic [SEL_W-1:0]  rf_writeSel;
    logic [DATA_W-1:0] rf_writeData;

    logic [SEL_W-1:0]  rd1_sel;
    logic              rd1_hit;
    logic [DATA_W-1:0] rd1_data;
    logic [SEL_W-1:0]  rd2_sel;
    logic              rd2_hit;
    logic [DATA_W-1:0] rd2_data;

    // Pipeline / register-file side
    modport master (
        output push_valid, push_sel, push_data, drain_en, rd1_sel, rd2_sel,
        input  push_ready, rf_writeEn, rf_writeSel, rf_writeData,
        input  rd1_hit, rd1_data, rd2_hit, rd2_data
    );

    // Queue side
    modport slave (
        input  push_valid, push_sel, push_data, drain_en, rd1_sel, rd2_sel,
        output push_ready, rf_writeEn, rf_writeSel, rf_writeData,
        output rd1_hit, rd1_data, rd2_hit, rd2_data
    );
endinterface

// File: rtl/rf_wb_queue.sv
// Write-back queue in front of the register file's single write port.
// Holds up to DEPTH pending {sel, data} writes, retires the head one per cycle
// when drain_en allows, and forwards the youngest pending value to both read ports.
module rf_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int SEL_W  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    rf_wb_queue_if.slave             bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [SEL_W-1:0]  sel_q  [DEPTH];
    logic [SEL_W-1:0]  sel_d  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              err_q, err_d;

    logic              full, empty, push_fire, pop_fire;
    logic [PTR_W-1:0]  scan_idx;

    // A full queue refuses pushes even when the head retires this cycle, so a
    // slot is never reused on the edge that frees it.
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign push_fire = bus.push_valid & ~full;
    assign pop_fire  = bus.drain_en & ~empty;

    assign bus.push_ready   = ~full;
    assign bus.rf_writeEn   = pop_fire;
    assign bus.rf_writeSel  = empty ? '0 : sel_q[head_q];
    assign bus.rf_writeData = empty ? '0 : data_q[head_q];
    assign count            = count_q;
    assign err              = err_q;

    // Next-state for pointers, occupancy, valid bits, entry storage and overflow flag
    always_comb begin
        sel_d   = sel_q;
        data_d  = data_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        err_d   = err_q | (bus.push_valid & full);

        if (pop_fire) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        if (push_fire) begin
            sel_d[tail_q]   = bus.push_sel;
            data_d[tail_q]  = bus.push_data;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + 1'b1;
        end

        case ({push_fire, pop_fire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Forwarding: walk from head (oldest) to youngest so the last match wins
    always_comb begin
        bus.rd1_hit  = 1'b0;
        bus.rd1_data = '0;
        bus.rd2_hit  = 1'b0;
        bus.rd2_data = '0;
        scan_idx     = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PTR_W'(i);
            if (valid_q[scan_idx] && (sel_q[scan_idx] == bus.rd1_sel)) begin
                bus.rd1_hit  = 1'b1;
                bus.rd1_data = data_q[scan_idx];
            end
            if (valid_q[scan_idx] && (sel_q[scan_idx] == bus.rd2_sel)) begin
                bus.rd2_hit  = 1'b1;
                bus.rd2_data = data_q[scan_idx];
            end
        end
    end

    // Control state; a reset drops every pending write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Entry payload storage; contents are masked by valid/empty so no reset is needed
    always_ff @(posedge clk) begin
        sel_q  <= sel_d;
        data_q <= data_d;
    end
endmodule

// File: tb/tb_rf_wb_queue.sv
// Bench for rf_wb_queue: directed scenarios followed by random traffic, checked
// against a queue-based reference model and an RF-write scoreboard.
module tb_rf_wb_queue;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 16;
    localparam int SEL_W  = 3;

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [$clog2(DEPTH):0] count;
    logic err;

    int checks = 0;
    int errors = 0;

    wr_t model_q[$];
    wr_t exp_q[$];
    wr_t mon_e;
    logic model_err = 1'b0;
    logic [DATA_W-1:0] rf_model [8];
    logic [7:0] rf_written = '0;

    rf_wb_queue_if #(.SEL_W(SEL_W), .DATA_W(DATA_W)) bus ();

    rf_wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .count (count),
        .err   (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every RF write the DUT presents must be the oldest expected one
    always @(negedge clk) begin
        if (rst && bus.rf_writeEn) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual_sel=%0d actual_data=%0h expected=none",
                         bus.rf_writeSel, bus.rf_writeData);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_sel", int'(bus.rf_writeSel), int'(mon_e.sel));
                chk("wr_data", int'(bus.rf_writeData), int'(mon_e.data));
            end
            rf_model[bus.rf_writeSel] = bus.rf_writeData;
            rf_written[bus.rf_writeSel] = 1'b1;
        end
    end

    task automatic check_outputs(input logic de, input logic [SEL_W-1:0] r1,
                                 input logic [SEL_W-1:0] r2);
        logic h1, h2;
        logic [DATA_W-1:0] d1, d2;
        int n;
        n  = model_q.size();
        h1 = 1'b0; d1 = '0; h2 = 1'b0; d2 = '0;
        for (int i = 0; i < n; i++) begin
            if (model_q[i].sel == r1) begin h1 = 1'b1; d1 = model_q[i].data; end
            if (model_q[i].sel == r2) begin h2 = 1'b1; d2 = model_q[i].data; end
        end
        chk("count", int'(count), n);
        chk("push_ready", int'(bus.push_ready), int'(n < DEPTH));
        chk("wr_en", int'(bus.rf_writeEn), int'(de && n > 0));
        chk("wr_sel_head", int'(bus.rf_writeSel), n > 0 ? int'(model_q[0].sel) : 0);
        chk("wr_data_head", int'(bus.rf_writeData), n > 0 ? int'(model_q[0].data) : 0);
        chk("rd1_hit", int'(bus.rd1_hit), int'(h1));
        chk("rd1_data", int'(bus.rd1_data), int'(d1));
        chk("rd2_hit", int'(bus.rd2_hit), int'(h2));
        chk("rd2_data", int'(bus.rd2_data), int'(d2));
        chk("err", int'(err), int'(model_err));
    endtask

    // One clock cycle: drive, issue expectation, check mid-cycle, then advance the model
    task automatic step(input logic pv, input logic [SEL_W-1:0] ps, input logic [DATA_W-1:0] pd,
                        input logic de, input logic [SEL_W-1:0] r1, input logic [SEL_W-1:0] r2);
        logic acc, pop;
        wr_t w;
        bus.push_valid = pv;
        bus.push_sel   = ps;
        bus.push_data  = pd;
        bus.drain_en   = de;
        bus.rd1_sel    = r1;
        bus.rd2_sel    = r2;
        w.sel  = ps;
        w.data = pd;
        acc = pv && (model_q.size() < DEPTH);
        if (acc) exp_q.push_back(w);
        @(negedge clk);
        check_outputs(de, r1, r2);
        @(posedge clk);
        #1;
        pop = de && (model_q.size() > 0);
        if (pop) void'(model_q.pop_front());
        if (acc) model_q.push_back(w);
        if (pv && !acc) model_err = 1'b1;
    endtask

    task automatic idle(input logic de, input logic [SEL_W-1:0] r1, input logic [SEL_W-1:0] r2);
        step(1'b0, '0, '0, de, r1, r2);
    endtask

    task automatic clear_model();
        model_q.delete();
        exp_q.delete();
        model_err = 1'b0;
    endtask

    initial begin
        bus.push_valid = 1'b0;
        bus.push_sel   = '0;
        bus.push_data  = '0;
        bus.drain_en   = 1'b0;
        bus.rd1_sel    = '0;
        bus.rd2_sel    = '0;
        for (int i = 0; i < 8; i++) rf_model[i] = '0;

        // Power-on reset
        #2 rst = 1'b0;
        #1;
        chk("rst_count", int'(count), 0);
        chk("rst_ready", int'(bus.push_ready), 1);
        chk("rst_wr_en", int'(bus.rf_writeEn), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_hit1", int'(bus.rd1_hit), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;

        // 1: push r3=0x1234 with drain held off, forward it on rd1
        step(1'b1, 3'd3, 16'h1234, 1'b0, 3'd3, 3'd0);
        idle(1'b0, 3'd3, 3'd0);

        // 2: retire it for one cycle, then nothing pending
        idle(1'b1, 3'd3, 3'd0);
        idle(1'b0, 3'd3, 3'd0);
        chk("rf_r3", int'(rf_model[3]), 16'h1234);

        // 3: three writes to r5, youngest forwarded, RF ends at youngest
        step(1'b1, 3'd5, 16'h0001, 1'b0, 3'd0, 3'd5);
        step(1'b1, 3'd5, 16'h0002, 1'b0, 3'd0, 3'd5);
        step(1'b1, 3'd5, 16'h0003, 1'b0, 3'd0, 3'd5);
        idle(1'b0, 3'd5, 3'd5);
        for (int k = 0; k < 4; k++) idle(1'b1, 3'd0, 3'd5);
        chk("rf_r5", int'(rf_model[5]), 16'h0003);

        // 4: fill, overflow attempts (one with a concurrent pop), then drain
        step(1'b1, 3'd0, 16'hA000, 1'b0, 3'd7, 3'd4);
        step(1'b1, 3'd1, 16'hA001, 1'b0, 3'd7, 3'd4);
        step(1'b1, 3'd2, 16'hA002, 1'b0, 3'd7, 3'd4);
        step(1'b1, 3'd4, 16'hA004, 1'b0, 3'd7, 3'd4);
        step(1'b1, 3'd7, 16'hBEEF, 1'b0, 3'd7, 3'd4);
        step(1'b1, 3'd7, 16'hBEEF, 1'b1, 3'd7, 3'd4);
        for (int k = 0; k < 5; k++) idle(1'b1, 3'd7, 3'd2);
        chk("r7_never_written", int'(rf_written[7]), 0);

        // 5: steady stream with drain enabled
        for (int k = 0; k < 20; k++)
            step(1'b1, SEL_W'($urandom_range(0, 7)), DATA_W'($urandom), 1'b1,
                 SEL_W'($urandom_range(0, 7)), SEL_W'($urandom_range(0, 7)));
        idle(1'b1, 3'd0, 3'd0);
        idle(1'b1, 3'd0, 3'd0);

        // 6: three pending entries, reset asserted mid-cycle while draining
        step(1'b1, 3'd6, 16'h6666, 1'b0, 3'd6, 3'd1);
        step(1'b1, 3'd1, 16'h1111, 1'b0, 3'd6, 3'd1);
        step(1'b1, 3'd2, 16'h2222, 1'b0, 3'd6, 3'd1);
        bus.push_valid = 1'b0;
        bus.drain_en   = 1'b1;
        #2 rst = 1'b0;
        #1;
        clear_model();
        chk("midrst_count", int'(count), 0);
        chk("midrst_wr_en", int'(bus.rf_writeEn), 0);
        chk("midrst_hit1", int'(bus.rd1_hit), 0);
        chk("midrst_hit2", int'(bus.rd2_hit), 0);
        chk("midrst_err", int'(err), 0);
        chk("midrst_ready", int'(bus.push_ready), 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("midrst_hold_wr_en", int'(bus.rf_writeEn), 0);
        rst = 1'b1;
        idle(1'b1, 3'd6, 3'd1);

        // Random traffic
        for (int k = 0; k < 300; k++)
            step(logic'($urandom_range(0, 9) < 7), SEL_W'($urandom_range(0, 7)), DATA_W'($urandom),
                 logic'($urandom_range(0, 1)), SEL_W'($urandom_range(0, 7)),
                 SEL_W'($urandom_range(0, 7)));
        for (int k = 0; k < 2 * DEPTH && model_q.size() > 0; k++)
            idle(1'b1, SEL_W'($urandom_range(0, 7)), SEL_W'($urandom_range(0, 7)));
        idle(1'b0, 3'd0, 3'd0);
        chk("final_count", int'(count), 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
